regfile_writeback: RTL and testbench
====================================

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 Parameter XLEN, default 32: data width of results and register-file write data.
REQ-002 Parameter DEPTH, default 2: entries in the internal writeback buffer; power of two, 2..8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 in_valid  input  1  upstream (MEM stage) result present.
REQ-006 in_ready  output  1  buffer can accept; transfer when in_valid && in_ready at a rising edge.
REQ-007 in_rd  input  5  destination register index.
REQ-008 in_wen  input  1  result must write the register file.
REQ-009 in_kind  input  3  0=ALU, 1=LB, 2=LH, 3=LW, 4=LBU, 5=LHU; 6,7 reserved.
REQ-010 in_off  input  2  load byte offset (address bits 1:0).
REQ-011 in_data  input  XLEN  ALU result or raw load word.
REQ-012 wb_stall  input  1  register-file port unavailable; hold the buffer head.
REQ-013 regWEn  output  1  register-file write enable, registered.
REQ-014 addrD  output  5  register-file write index, registered.
REQ-015 dataD  output  XLEN  register-file write data, registered.
REQ-016 fwd_valid  output  1  newest buffered/outgoing write for fwd_addr present.
REQ-017 fwd_addr  output  5  index of newest pending write.
REQ-018 fwd_data  output  XLEN  aligned data of newest pending write.
REQ-019 retire_cnt  output  32  count of completed register writes.

Function
REQ-020 Buffer SHALL be a DEPTH-entry FIFO with wrapping read/write pointers and an occupancy counter 0..DEPTH.
REQ-021 in_ready SHALL equal (occupancy < DEPTH); accepting when full is impossible, in_valid while full is held by upstream.
REQ-022 Accepted entries with in_wen=0 or in_rd=0 SHALL be discarded (no buffer slot consumed, no write, no count).
REQ-023 Alignment SHALL be applied at accept: LB/LBU select byte in_off, LH/LHU select halfword in_off[1]; LB/LH sign-extend, LBU/LHU zero-extend; LW and ALU pass in_data; reserved kinds treated as ALU.
REQ-024 Misaligned LH/LHU (in_off[0]=1) SHALL use halfword in_off[1] and ignore in_off[0].
REQ-025 Each cycle with wb_stall=0 and occupancy>0, the head SHALL pop and be loaded into regWEn=1/addrD/dataD at that edge; otherwise regWEn SHALL load 0 and addrD/dataD hold.
REQ-026 Minimum latency: accept at edge N into an empty buffer, regWEn high during the cycle after edge N+1.
REQ-027 Simultaneous accept and pop when full SHALL NOT be allowed (in_ready=0); when not full, simultaneous push and pop leave occupancy unchanged.
REQ-028 Entries SHALL retire strictly in acceptance order.
REQ-029 fwd_* SHALL report the most recently accepted entry still in the buffer, else the output register if regWEn=1; fwd_valid=0 when neither exists.
REQ-030 retire_cnt SHALL increment by 1 on each edge where regWEn is loaded with 1, wrapping 0xFFFFFFFF->0.
REQ-031 The FSM SHALL have states EMPTY, PARTIAL, FULL, derived from occupancy: EMPTY->PARTIAL on push-only, PARTIAL->FULL on push-only at DEPTH-1, FULL->PARTIAL on pop, PARTIAL->EMPTY on pop-only at 1.

Reset
REQ-032 rst_n low SHALL immediately clear occupancy, pointers, regWEn, addrD, dataD, fwd_valid, fwd_addr, fwd_data, retire_cnt to 0; in_ready=1 while held.
REQ-033 Reset asserted mid-operation SHALL discard all buffered entries with no further register write; release is synchronous to clk.

Verification
REQ-034 Accept ALU rd=5 data 0xDEADBEEF, wb_stall=0 -> regWEn=1, addrD=5, dataD=0xDEADBEEF two edges later; retire_cnt=1.
REQ-035 LB off=3 data 0x80112233 -> dataD=0xFFFFFF80; LHU off=2 same data -> dataD=0x00008011.
REQ-036 wb_stall=1, push rd=1,2 -> in_ready=0, fwd_addr=2; third push held; release stall -> writes rd=1 then rd=2 on consecutive cycles.
REQ-037 Push rd=0 and rd=7 with in_wen=0 -> no regWEn pulse, retire_cnt unchanged, occupancy 0.
REQ-038 Buffer full, assert rst_n=0 between edges -> regWEn=0, in_ready=1 immediately; no write after release.
REQ-039 Preset retire_cnt to 0xFFFFFFFF via 2^32-1 retirements (or forced) then one write -> retire_cnt=0.

Source files
------------

// File: rtl/regfile_writeback.sv
// ---------------------------------------------------------------------------
// regfile_writeback: aligns MEM-stage results into a small FIFO and drains them
// into the register-file write port, with forwarding of the newest pending write.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_writeback #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd,
  input  logic            in_wen,
  input  logic [2:0]      in_kind,
  input  logic [1:0]      in_off,
  input  logic [XLEN-1:0] in_data,
  input  logic            wb_stall,
  output logic            regWEn,
  output logic [4:0]      addrD,
  output logic [XLEN-1:0] dataD,
  output logic            fwd_valid,
  output logic [4:0]      fwd_addr,
  output logic [XLEN-1:0] fwd_data,
  output logic [31:0]     retire_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] OCC_ONE  = CW'(1);
  localparam logic [CW-1:0] OCC_LAST = CW'(DEPTH - 1);

  typedef enum logic [1:0] {EMPTY = 2'd0, PARTIAL = 2'd1, FULL = 2'd2} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   wptr, rptr, newest;
  logic [CW-1:0]   occ;
  logic [4:0]      rd_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];

  logic            push, pop;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] aligned;

  assign in_ready = (state != FULL);
  // Writes that can never reach the register file never occupy a slot.
  assign push     = in_valid && in_ready && in_wen && (in_rd != 5'd0);
  assign pop      = !wb_stall && (state != EMPTY);
  assign newest   = wptr - PW'(1);

  always_comb begin
    byte_sel = in_data[{in_off, 3'b000} +: 8];
    half_sel = in_data[{in_off[1], 4'b0000} +: 16];
    aligned  = in_data;
    case (in_kind)
      3'd1:    aligned = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      3'd2:    aligned = {{(XLEN-16){half_sel[15]}}, half_sel};
      3'd4:    aligned = {{(XLEN-8){1'b0}}, byte_sel};
      3'd5:    aligned = {{(XLEN-16){1'b0}}, half_sel};
      default: aligned = in_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wptr]   <= in_rd;
      data_mem[wptr] <= aligned;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      wptr       <= '0;
      rptr       <= '0;
      occ        <= '0;
      regWEn     <= 1'b0;
      addrD      <= '0;
      dataD      <= '0;
      retire_cnt <= '0;
    end else begin
      state  <= state_nx;
      regWEn <= pop;
      if (push) wptr <= wptr + PW'(1);
      if (pop) begin
        rptr       <= rptr + PW'(1);
        addrD      <= rd_mem[rptr];
        dataD      <= data_mem[rptr];
        retire_cnt <= retire_cnt + 32'd1;
      end
      if (push && !pop)      occ <= occ + OCC_ONE;
      else if (pop && !push) occ <= occ - OCC_ONE;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   if (push) state_nx = PARTIAL;
      PARTIAL: begin
        if (push && !pop && occ == OCC_LAST)     state_nx = FULL;
        else if (pop && !push && occ == OCC_ONE) state_nx = EMPTY;
      end
      FULL:    if (pop) state_nx = PARTIAL;
      default: state_nx = EMPTY;
    endcase
  end

  // Buffered entries are younger than whatever sits in the output register.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_addr  = '0;
    fwd_data  = '0;
    if (state != EMPTY) begin
      fwd_valid = 1'b1;
      fwd_addr  = rd_mem[newest];
      fwd_data  = data_mem[newest];
    end else if (regWEn) begin
      fwd_valid = 1'b1;
      fwd_addr  = addrD;
      fwd_data  = dataD;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_writeback.sv
// ---------------------------------------------------------------------------
// tb_regfile_writeback: directed and random stimulus against a queue model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_regfile_writeback;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0, in_wen = 1'b0, wb_stall = 1'b0;
  logic [4:0]      in_rd = '0;
  logic [2:0]      in_kind = '0;
  logic [1:0]      in_off = '0;
  logic [XLEN-1:0] in_data = '0;
  logic            in_ready, regWEn, fwd_valid;
  logic [4:0]      addrD, fwd_addr;
  logic [XLEN-1:0] dataD, fwd_data;
  logic [31:0]     retire_cnt;

  regfile_writeback #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_wen(in_wen), .in_kind(in_kind), .in_off(in_off),
    .in_data(in_data), .wb_stall(wb_stall), .regWEn(regWEn), .addrD(addrD),
    .dataD(dataD), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic        m_wen;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] m_cnt;

  function automatic logic [31:0] align(input logic [2:0] kind, input logic [1:0] off,
                                        input logic [31:0] data);
    logic [31:0] b, h;
    b = (data >> (8 * off)) & 32'h0000_00FF;
    h = (data >> (16 * (off / 2))) & 32'h0000_FFFF;
    case (kind)
      3'd1:    return (b ^ 32'h80) - 32'h80;
      3'd2:    return (h ^ 32'h8000) - 32'h8000;
      3'd4:    return b;
      3'd5:    return h;
      default: return data;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic        ev;
    logic [4:0]  ea;
    logic [31:0] ed;
    ev = 1'b0; ea = '0; ed = '0;
    if (q.size() > 0) begin
      ev = 1'b1; ea = q[q.size()-1].rd; ed = q[q.size()-1].data;
    end else if (m_wen) begin
      ev = 1'b1; ea = m_addr; ed = m_data;
    end
    chk({tag, ".regWEn"},     32'(regWEn),    32'(m_wen));
    chk({tag, ".addrD"},      32'(addrD),     32'(m_addr));
    chk({tag, ".dataD"},      dataD,          m_data);
    chk({tag, ".retire_cnt"}, retire_cnt,     m_cnt);
    chk({tag, ".in_ready"},   32'(in_ready),  32'(q.size() < DEPTH));
    chk({tag, ".fwd_valid"},  32'(fwd_valid), 32'(ev));
    chk({tag, ".fwd_addr"},   32'(fwd_addr),  32'(ea));
    chk({tag, ".fwd_data"},   fwd_data,       ed);
  endtask

  // Drive one cycle's inputs, advance the model across the edge, then compare.
  task automatic cycle(input string tag, input logic v, input logic [4:0] rd,
                       input logic wen, input logic [2:0] kind, input logic [1:0] off,
                       input logic [31:0] data, input logic stall);
    logic acc;
    ent_t h;
    in_valid = v; in_rd = rd; in_wen = wen; in_kind = kind;
    in_off = off; in_data = data; wb_stall = stall;
    @(posedge clk);
    acc = v && (q.size() < DEPTH);
    if (!stall && q.size() > 0) begin
      h = q.pop_front();
      m_wen = 1'b1; m_addr = h.rd; m_data = h.data; m_cnt = m_cnt + 32'd1;
    end else begin
      m_wen = 1'b0;
    end
    if (acc && wen && rd != 5'd0) q.push_back('{rd, align(kind, off, data)});
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 32'h0, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    m_wen = 1'b0; m_addr = '0; m_data = '0; m_cnt = '0;
    check_all(tag);
    @(negedge clk);
    in_valid = 1'b0; wb_stall = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    m_wen = 1'b0; m_addr = '0; m_data = '0; m_cnt = '0;
    @(negedge clk);
    do_reset("reset0");

    // Single ALU write, two edges of latency.
    cycle("alu_acc", 1'b1, 5'd5, 1'b1, 3'd0, 2'd0, 32'hDEADBEEF, 1'b0);
    chk("alu_lat_regWEn0", 32'(regWEn), 32'd0);
    idle("alu_pop");
    chk("alu_regWEn", 32'(regWEn), 32'd1);
    chk("alu_addrD", 32'(addrD), 32'd5);
    chk("alu_dataD", dataD, 32'hDEADBEEF);
    chk("alu_cnt", retire_cnt, 32'd1);

    // Load alignment: LB byte 3 and LHU halfword 1.
    cycle("lb_acc",  1'b1, 5'd9,  1'b1, 3'd1, 2'd3, 32'h80112233, 1'b0);
    cycle("lhu_acc", 1'b1, 5'd10, 1'b1, 3'd5, 2'd2, 32'h80112233, 1'b0);
    chk("lb_dataD", dataD, 32'hFFFFFF80);
    idle("lhu_pop");
    chk("lhu_dataD", dataD, 32'h00008011);
    cycle("lh_mis", 1'b1, 5'd11, 1'b1, 3'd2, 2'd3, 32'h80112233, 1'b0);
    idle("lh_mis_pop");
    chk("lh_mis_dataD", dataD, 32'hFFFF8011);
    idle("drain0");

    // Discarded writes: rd=0 and in_wen=0.
    cycle("rd0",  1'b1, 5'd0, 1'b1, 3'd0, 2'd0, 32'h12345678, 1'b0);
    cycle("wen0", 1'b1, 5'd7, 1'b0, 3'd0, 2'd0, 32'h87654321, 1'b0);
    idle("discard_idle");
    chk("discard_regWEn", 32'(regWEn), 32'd0);
    chk("discard_cnt", retire_cnt, 32'd4);

    // Stall fills the buffer, third push held, then drains in order.
    cycle("st_p1", 1'b1, 5'd1, 1'b1, 3'd0, 2'd0, 32'h11111111, 1'b1);
    cycle("st_p2", 1'b1, 5'd2, 1'b1, 3'd0, 2'd0, 32'h22222222, 1'b1);
    chk("st_full_ready", 32'(in_ready), 32'd0);
    chk("st_fwd_addr", 32'(fwd_addr), 32'd2);
    cycle("st_hold", 1'b1, 5'd3, 1'b1, 3'd0, 2'd0, 32'h33333333, 1'b1);
    cycle("st_rel1", 1'b1, 5'd3, 1'b1, 3'd0, 2'd0, 32'h33333333, 1'b0);
    chk("st_w1", 32'(addrD), 32'd1);
    cycle("st_rel2", 1'b1, 5'd3, 1'b1, 3'd0, 2'd0, 32'h33333333, 1'b0);
    chk("st_w2", 32'(addrD), 32'd2);
    chk("st_w2_en", 32'(regWEn), 32'd1);
    idle("st_rel3");
    chk("st_w3", 32'(addrD), 32'd3);
    idle("st_drain");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle("rnd", 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 2) == 0));
    end

    // Reset while full: no writes afterward.
    cycle("rf_p1", 1'b1, 5'd4, 1'b1, 3'd0, 2'd0, 32'hAAAA0001, 1'b1);
    cycle("rf_p2", 1'b1, 5'd6, 1'b1, 3'd0, 2'd0, 32'hAAAA0002, 1'b1);
    do_reset("rf_reset");
    chk("rf_ready", 32'(in_ready), 32'd1);
    idle("rf_post1");
    idle("rf_post2");
    chk("rf_no_write", 32'(regWEn), 32'd0);

    // Counter wrap.
    #1 force dut.retire_cnt = 32'hFFFFFFFF;
    #1 release dut.retire_cnt;
    m_cnt = 32'hFFFFFFFF;
    @(negedge clk);
    cycle("wrap_acc", 1'b1, 5'd8, 1'b1, 3'd3, 2'd0, 32'hCAFEF00D, 1'b0);
    idle("wrap_pop");
    chk("wrap_cnt", retire_cnt, 32'd0);
    idle("wrap_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
